// File: rtl/axi_stream_packet_output.sv
// AXI4-Stream master: captures an N-character vector and streams it as one packet,
// LANES characters per beat, through a small beat FIFO with per-lane TKEEP and TLAST.
module axi_stream_packet_output #(
   parameter int CHAR_LEN  = 8,
   parameter int N         = 16,
   parameter int LANES     = 4,
   parameter int DEPTH     = 8,
   parameter int LOG_DEPTH = 3
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   output logic [LANES*CHAR_LEN-1:0] M_AXIS_TDATA,
   output logic [LANES-1:0]          M_AXIS_TKEEP,
   output logic                      M_AXIS_TLAST,
   output logic                      M_AXIS_TVALID,
   input  logic                      M_AXIS_TREADY,
   input  logic                      run,
   input  logic [N*CHAR_LEN-1:0]     d,
   output logic                      valid,
   output logic                      aborted
);

   localparam int BEATS     = (N + LANES - 1) / LANES;
   localparam int LAST_KEEP = N - (BEATS - 1) * LANES;
   localparam int BW        = $clog2(BEATS + 1);
   localparam int IW        = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int W         = LANES * CHAR_LEN;
   localparam int EW        = W + LANES + 1;
   localparam int SW        = BEATS * W;

   function automatic logic [LANES-1:0] low_mask(input int n);
      logic [LANES-1:0] m;
      for (int k = 0; k < LANES; k++) begin
         m[k] = (k < n) ? 1'b1 : 1'b0;
      end
      return m;
   endfunction

   localparam logic [LANES-1:0] LAST_KEEP_MASK = low_mask(LAST_KEEP);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [BW-1:0]        beat_q, beat_d;
   logic [SW-1:0]        shadow_q, shadow_d, padded_s;
   logic                 valid_q, valid_d;
   logic                 aborted_q, aborted_d;
   logic [EW-1:0]        mem_q [DEPTH];
   logic [LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [LOG_DEPTH:0]   count_q, count_d;
   logic                 full_s, wr_s, rd_s, last_s;
   logic [LANES-1:0]     keep_s;
   logic [W-1:0]         wdata_s;
   logic [IW-1:0]        beat_idx_s;
   logic [EW-1:0]        head_s;

   // Zero-extend the character vector to a whole number of beats.
   always_comb begin
      padded_s = {SW{1'b0}};
      padded_s[N*CHAR_LEN-1:0] = d;
   end

   // Beat currently being written: data slice, keep mask and last flag.
   always_comb begin
      beat_idx_s = beat_q[IW-1:0];
      wdata_s    = shadow_q[int'(beat_idx_s)*W +: W];
      last_s     = (beat_q == BW'(BEATS - 1));
      keep_s     = last_s ? LAST_KEEP_MASK : {LANES{1'b1}};
   end

   // Packet sequencer next-state.
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      shadow_d  = shadow_q;
      wr_s      = 1'b0;
      aborted_d = 1'b0;
      case (state_q)
         IDLE: begin
            beat_d = BW'(0);
            if (run) begin
               state_d  = SEND;
               shadow_d = padded_s;
            end else begin
               state_d = IDLE;
            end
         end
         SEND: begin
            if (!run) begin
               state_d   = IDLE;
               beat_d    = BW'(0);
               aborted_d = (beat_q != BW'(0));
            end else if (!full_s) begin
               wr_s   = 1'b1;
               beat_d = beat_q + BW'(1);
               if (last_s) begin
                  state_d = DONE;
               end else begin
                  state_d = SEND;
               end
            end else begin
               state_d = SEND;
            end
         end
         DONE: begin
            if (!run) begin
               state_d = IDLE;
               beat_d  = BW'(0);
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
            beat_d  = BW'(0);
         end
      endcase
      valid_d = (state_d == DONE);
   end

   // Sequencer registers.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q   <= IDLE;
         beat_q    <= BW'(0);
         shadow_q  <= {SW{1'b0}};
         valid_q   <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         shadow_q  <= shadow_d;
         valid_q   <= valid_d;
         aborted_q <= aborted_d;
      end
   end

   // Full is judged on occupancy before this edge's read, so a same-edge read never frees a slot.
   always_comb begin
      full_s = (count_q == (LOG_DEPTH+1)'(DEPTH));
      rd_s   = M_AXIS_TVALID & M_AXIS_TREADY;
      case ({wr_s, rd_s})
         2'b10:   count_d = count_q + (LOG_DEPTH+1)'(1);
         2'b01:   count_d = count_q - (LOG_DEPTH+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_ptr_q <= LOG_DEPTH'(0);
         rd_ptr_q <= LOG_DEPTH'(0);
         count_q  <= (LOG_DEPTH+1)'(0);
      end else begin
         wr_ptr_q <= wr_s ? wr_ptr_q + LOG_DEPTH'(1) : wr_ptr_q;
         rd_ptr_q <= rd_s ? rd_ptr_q + LOG_DEPTH'(1) : rd_ptr_q;
         count_q  <= count_d;
      end
   end

   // FIFO storage.
   always_ff @(posedge ACLK) begin
      if (wr_s) begin
         mem_q[wr_ptr_q] <= {last_s, keep_s, wdata_s};
      end else begin
         mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
      end
   end

   // Head entry drives the stream; forced to zero while empty.
   always_comb begin
      head_s        = mem_q[rd_ptr_q];
      M_AXIS_TVALID = (count_q != (LOG_DEPTH+1)'(0));
      if (M_AXIS_TVALID) begin
         M_AXIS_TDATA = head_s[W-1:0];
         M_AXIS_TKEEP = head_s[W +: LANES];
         M_AXIS_TLAST = head_s[EW-1];
      end else begin
         M_AXIS_TDATA = {W{1'b0}};
         M_AXIS_TKEEP = {LANES{1'b0}};
         M_AXIS_TLAST = 1'b0;
      end
      valid   = valid_q;
      aborted = aborted_q;
   end

endmodule

// File: tb/tb_axi_stream_packet_output.sv
// Randomized bench for axi_stream_packet_output against a queue-based packet model.
module tb_axi_stream_packet_output;

   localparam int CL = 8;
   localparam int NC = 22;
   localparam int LN = 4;
   localparam int DP = 4;
   localparam int LD = 2;
   localparam int NB = (NC + LN - 1) / LN;

   logic              ACLK = 1'b0;
   logic              ARESET;
   logic [LN*CL-1:0]  tdata;
   logic [LN-1:0]     tkeep;
   logic              tlast, tvalid, tready, run, valid, aborted;
   logic [NC*CL-1:0]  d;

   always #5 ACLK = ~ACLK;

   axi_stream_packet_output #(
      .CHAR_LEN(CL), .N(NC), .LANES(LN), .DEPTH(DP), .LOG_DEPTH(LD)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .M_AXIS_TDATA(tdata), .M_AXIS_TKEEP(tkeep), .M_AXIS_TLAST(tlast),
      .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready),
      .run(run), .d(d), .valid(valid), .aborted(aborted)
   );

   typedef struct packed {
      logic          last;
      logic [LN-1:0] keep;
      logic [LN*CL-1:0] data;
   } beat_t;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          m_phase  = 0;   // 0 idle, 1 sending, 2 complete
   int          m_written = 0;
   bit          m_abort  = 1'b0;
   logic [CL-1:0] m_chars [NC];
   beat_t       mq [$];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic beat_t make_beat(input int b);
      beat_t e;
      e = '0;
      for (int k = 0; k < LN; k++) begin
         if (b*LN + k < NC) begin
            e.data[k*CL +: CL] = m_chars[b*LN + k];
            e.keep[k] = 1'b1;
         end
      end
      e.last = (b == NB - 1);
      return e;
   endfunction

   task automatic model_edge();
      bit pop, full;
      if (ARESET) begin
         mq.delete();
         m_phase = 0; m_written = 0; m_abort = 1'b0;
      end else begin
         pop = (mq.size() != 0) && tready;
         full = (mq.size() == DP);
         m_abort = 1'b0;
         if (pop) void'(mq.pop_front());
         if (!run) begin
            if (m_phase == 1 && m_written > 0) m_abort = 1'b1;
            m_phase = 0; m_written = 0;
         end else if (m_phase == 0) begin
            for (int i = 0; i < NC; i++) m_chars[i] = d[i*CL +: CL];
            m_phase = 1; m_written = 0;
         end else if (m_phase == 1 && !full) begin
            mq.push_back(make_beat(m_written));
            m_written++;
            if (m_written == NB) m_phase = 2;
         end
      end
   endtask

   task automatic check_outputs();
      check_eq("tvalid", 64'(tvalid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         check_eq("tdata", 64'(tdata), 64'(mq[0].data));
         check_eq("tkeep", 64'(tkeep), 64'(mq[0].keep));
         check_eq("tlast", 64'(tlast), 64'(mq[0].last));
      end
      check_eq("valid", 64'(valid), 64'(m_phase == 2));
      check_eq("aborted", 64'(aborted), 64'(m_abort));
   endtask

   task automatic cycle();
      @(posedge ACLK);
      model_edge();
      @(negedge ACLK);
      check_outputs();
   endtask

   task automatic rand_d();
      for (int i = 0; i < NC; i++) d[i*CL +: CL] = CL'($urandom);
   endtask

   initial begin
      ARESET = 1'b1; run = 1'b0; tready = 1'b0;
      for (int i = 0; i < NC; i++) d[i*CL +: CL] = CL'(i);
      repeat (2) cycle();
      check_eq("rst_tdata", 64'(tdata), 64'd0);
      check_eq("rst_tkeep", 64'(tkeep), 64'd0);
      check_eq("rst_tlast", 64'(tlast), 64'd0);

      // Full packet at full rate; d scrambled after capture; run held past DONE.
      ARESET = 1'b0; run = 1'b1; tready = 1'b1;
      cycle();
      check_eq("first_word_seq", 64'(m_chars[3]), 64'h03);
      repeat (14) begin rand_d(); cycle(); end
      run = 1'b0; cycle();

      // Backpressure until full, then drain.
      run = 1'b1; tready = 1'b0;
      repeat (10) cycle();
      tready = 1'b1;
      repeat (10) cycle();
      run = 1'b0; cycle();

      // Abort after two written beats, then drain and restart.
      run = 1'b1; tready = 1'b0;
      repeat (3) cycle();
      run = 1'b0; cycle();
      tready = 1'b1;
      repeat (4) cycle();
      run = 1'b1; rand_d();
      repeat (10) cycle();
      run = 1'b0; cycle();

      // Reset with three beats queued.
      run = 1'b1; tready = 1'b0;
      repeat (4) cycle();
      ARESET = 1'b1; cycle();
      ARESET = 1'b0; run = 1'b0; cycle();

      // Random traffic.
      repeat (500) begin
         if ($urandom_range(9) == 0) run = ~run;
         tready = 1'($urandom_range(1));
         ARESET = ($urandom_range(149) == 0);
         rand_d();
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
